// File: rtl/fetch_queue.sv
// fetch_queue: fetch-PC generator plus DEPTH-entry prefetch queue between imem and decode.
// Define FETCHQ_DBG_EN to add the dbg_sel/dbg_data debug port and push/redirect counters.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [XLEN-1:0]          imem_addr,
  output logic                     imem_req,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     imem_valid,
  output logic                     dq_valid,
  output logic [XLEN-1:0]          dq_instr,
  output logic [XLEN-1:0]          dq_pc,
  output logic [XLEN-1:0]          dq_pcplus4,
  input  logic                     dq_ready,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
`ifdef FETCHQ_DBG_EN
  input  logic [3:0]               dbg_sel,
  output logic [XLEN-1:0]          dbg_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] r_fpc;
  logic [AW-1:0]   r_head, r_tail;
  logic [AW:0]     r_count;
  logic [XLEN-1:0] r_pc [DEPTH];
  logic [XLEN-1:0] r_instr [DEPTH];
  logic            w_full, w_empty, w_push, w_pop;
  assign w_full    = r_count == (AW+1)'(DEPTH);
  assign w_empty   = r_count == '0;
  assign imem_req  = !w_full;
  assign imem_addr = r_fpc;
  assign w_push    = imem_req & imem_valid & !redirect;
  assign w_pop     = dq_valid & dq_ready & !redirect;
  assign count     = r_count;
  assign dq_valid   = !w_empty;
  assign dq_instr   = w_empty ? '0 : r_instr[r_head];
  assign dq_pc      = w_empty ? '0 : r_pc[r_head];
  assign dq_pcplus4 = w_empty ? '0 : r_pc[r_head] + XLEN'(PC_STEP);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_fpc   <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_fpc   <= redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fpc  <= r_fpc + XLEN'(PC_STEP);
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // Storage is never cleared; flush and reset only move the pointers.
  always_ff @(posedge clk)
    if (w_push) begin
      r_pc[r_tail]    <= r_fpc;
      r_instr[r_tail] <= imem_rdata;
    end
`ifdef FETCHQ_DBG_EN
  logic [XLEN-1:0] r_push_cnt, r_redir_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_push_cnt  <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_push_cnt  <= r_push_cnt + XLEN'(w_push);
      r_redir_cnt <= r_redir_cnt + XLEN'(redirect);
    end
  always_comb
    dbg_data = dbg_sel == 4'd1 ? dq_instr :
               dbg_sel == 4'd2 ? dq_pc :
               dbg_sel == 4'd3 ? XLEN'(r_count) :
               dbg_sel == 4'd4 ? r_push_cnt :
               dbg_sel == 4'd5 ? r_redir_cnt : r_fpc;
`endif
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined MIPS core. It replaces the single PC register and IF/ID latch with a fetch-PC generator and a DEPTH-entry prefetch queue, so decode stalls no longer freeze instruction memory. Memory wait states are tolerated through a valid handshake. Branch/jump redirects flush the queue in one cycle. The block sits between instruction memory and the decode stage.

## Interface
Parameters:
- XLEN, 32, width of PC and instruction words
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, fetch PC after reset
- PC_STEP, 4, byte increment per fetched instruction

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  XLEN  fetch PC (the fpc register)
- imem_req  out  1  fetch request; equals !full
- imem_rdata  in  XLEN  instruction word; meaningful only when imem_valid=1
- imem_valid  in  1  imem_rdata is valid for imem_addr this cycle
- dq_valid  out  1  queue head holds an instruction
- dq_instr  out  XLEN  head instruction; 0 (MIPS NOP) when empty
- dq_pc  out  XLEN  PC of head instruction; 0 when empty
- dq_pcplus4  out  XLEN  dq_pc + PC_STEP; 0 when empty
- dq_ready  in  1  decode accepts head this cycle (the inverse of the decode stall)
- redirect  in  1  branch taken or jump; flushes queue
- redirect_pc  in  XLEN  new fetch PC when redirect=1
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State:
  - fpc
  - head and tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH
  - count
  - DEPTH entries of {pc, instr}
- full = (count == DEPTH); empty = (count == 0).
- push = imem_req & imem_valid & !redirect. Push writes {fpc, imem_rdata} at the tail, advances tail, and sets fpc <= fpc + PC_STEP (modulo 2^XLEN).
- pop = dq_valid & dq_ready & !redirect. Pop advances head.
- count updates as count + push − pop. Simultaneous push and pop leave count unchanged.
- When full, imem_req=0 and nothing is pushed, even if a pop occurs in the same cycle. There is no combinational path from dq_ready to imem_req.
- When imem_valid=0 and the queue is not full: fpc holds and imem_req stays 1 (wait state).
- redirect=1 has priority over everything else:
  - fpc <= redirect_pc
  - head, tail and count are cleared to 0
  - push and pop are suppressed
  - imem_valid and dq_ready are ignored in that cycle
- Entries are not cleared by flush; only the pointers move.
- Head outputs are combinational from the head entry, gated to 0 when empty.

## Timing
- Reset values (asynchronous, while reset=0):
  - fpc=RESET_PC, count=0, pointers=0
  - dq_valid=0; dq_instr, dq_pc and dq_pcplus4 all 0
  - imem_addr=RESET_PC, imem_req=1
- Fetch-to-decode latency: an instruction pushed at edge N is on dq_* from edge N onward. It is visible in the cycle after the imem_valid cycle. There is no same-cycle bypass.
- Steady-state throughput is one instruction per cycle with imem_valid=1 and dq_ready=1.
- Redirect latency: redirect asserted in cycle N gives imem_addr=redirect_pc and dq_valid=0 in cycle N+1. The first redirected instruction appears at the earliest in cycle N+2.
- Reset deasserting mid-operation has no special case. Asserting reset mid-fill discards all entries immediately.
- dq_ready while empty is ignored. Redirect while empty still loads fpc.

## Configuration
- FETCHQ_DBG_EN defined: adds these ports.
  - dbg_sel  in  4  selects the debug word
  - dbg_data  out  XLEN  combinational debug word
- dbg_data selection:
  - 0: fpc
  - 1: dq_instr
  - 2: dq_pc
  - 3: count, zero-extended
  - 4: push counter
  - 5: redirect counter
  - any other value: fpc
- The push and redirect counters are XLEN-bit, free-running and wrapping, and reset to 0.
- FETCHQ_DBG_EN undefined: dbg_sel, dbg_data and both counters do not exist. Functional behaviour is identical.

## Test plan
- Reset then stream: reset low 3 cycles, release, imem_valid=1, dq_ready=1, imem_rdata=0x2000_0000+PC → dq_pc goes 0,4,8,… one per cycle from the second post-reset cycle; dq_instr = 0x2000_0000+dq_pc.
- Fill: DEPTH=4, dq_ready=0, imem_valid=1 → count 1,2,3,4; imem_req=0 at count=4; imem_addr holds 0x10; dq_pc stays 0.
- Full with pop: count=4, dq_ready=1 for 1 cycle → count=3 next cycle with no push that cycle; following cycle push resumes at 0x10.
- Wait states: imem_valid toggled 0,0,1 → imem_addr holds for 3 cycles, exactly one push, fpc then +4.
- Redirect mid-fill: count=3, redirect=1, redirect_pc=0x0000_0400, imem_valid=1, dq_ready=1 → next cycle count=0, dq_valid=0, dq_instr=0, imem_addr=0x400; next head dq_pc=0x400, dq_pcplus4=0x404.
- Debug (FETCHQ_DBG_EN): after 6 pushes and 1 redirect, dbg_sel=4 → 6, dbg_sel=5 → 1, dbg_sel=15 → fpc.
